// File: rtl/pio_led_blink.sv
// Avalon-MM LED output port: data register with set/clear/toggle aliases and
// per-channel blink gated by a shared down-counting prescaler.
module pio_led_blink #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      PRESCALE_W  = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_address,
  input  logic             i_chipselect,
  input  logic             i_write_n,
  input  logic [31:0]      i_writedata,
  output logic [31:0]      o_readdata,
  output logic [WIDTH-1:0] o_out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_SET    = 3'd3;
  localparam logic [2:0] ADDR_CLEAR  = 3'd4;
  localparam logic [2:0] ADDR_TOGGLE = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;

  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_mode;
  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_en;
  logic                  r_phase;
  logic [WIDTH-1:0]      r_out;

  logic                  w_wr;
  logic                  w_period_wr;
  logic                  w_ctrl_wr;
  logic                  w_cnt_zero;
  logic [WIDTH-1:0]      w_wd;
  logic [PRESCALE_W-1:0] w_wd_per;
  logic                  w_unused;

  assign w_wr        = i_chipselect && !i_write_n;
  assign w_period_wr = w_wr && (i_address == ADDR_PERIOD);
  assign w_ctrl_wr   = w_wr && (i_address == ADDR_CTRL);
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_wd        = i_writedata[WIDTH-1:0];
  assign w_wd_per    = i_writedata[PRESCALE_W-1:0];
  // Upper writedata bits are legitimately ignored for narrow configurations.
  assign w_unused    = ^i_writedata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data   <= RESET_VALUE;
      r_mode   <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_phase  <= 1'b1;
      r_out    <= RESET_VALUE;
    end else begin
      r_out <= r_data & (~r_mode | {WIDTH{r_phase}});

      if (w_wr) begin
        case (i_address)
          ADDR_DATA:   r_data <= w_wd;
          ADDR_MODE:   r_mode <= w_wd;
          ADDR_SET:    r_data <= r_data | w_wd;
          ADDR_CLEAR:  r_data <= r_data & ~w_wd;
          ADDR_TOGGLE: r_data <= r_data ^ w_wd;
          default:     ;
        endcase
      end

      // A PERIOD write reloads the counter and suppresses this cycle's toggle.
      if (w_period_wr) begin
        r_period <= w_wd_per;
        r_cnt    <= w_wd_per;
      end else if (r_en) begin
        if (w_cnt_zero) r_cnt <= r_period;
        else            r_cnt <= r_cnt - PRESCALE_W'(1);
      end

      if (w_ctrl_wr) r_en <= i_writedata[0];

      if (w_ctrl_wr && !i_writedata[0]) r_phase <= 1'b1;
      else if (!r_en)                   r_phase <= 1'b1;
      else if (w_cnt_zero && !w_period_wr) r_phase <= ~r_phase;
    end
  end

  always_comb begin
    o_readdata = '0;
    case (i_address)
      ADDR_DATA:   o_readdata[WIDTH-1:0]      = r_data;
      ADDR_MODE:   o_readdata[WIDTH-1:0]      = r_mode;
      ADDR_PERIOD: o_readdata[PRESCALE_W-1:0] = r_period;
      ADDR_CTRL:   o_readdata[1:0]            = {r_phase, r_en};
      default:     ;
    endcase
  end

  assign o_out_port = r_out;

endmodule

// File: tb/tb_pio_led_blink.sv
// Self-checking bench for pio_led_blink: expected out_port values are queued
// with their due cycle and compared by a monitor when that cycle arrives.
module tb_pio_led_blink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         due;
    string      tag;
    logic [7:0] val;
  } sb_t;
  sb_t sb_q[$];

  pio_led_blink #(
    .WIDTH(8),
    .PRESCALE_W(24),
    .RESET_VALUE(8'hA5)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_address(address),
    .i_chipselect(chipselect),
    .i_write_n(write_n),
    .i_writedata(writedata),
    .o_readdata(readdata),
    .o_out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk_eq(tag, readdata, exp);
  endtask

  task automatic sb_push(input int due, input string tag, input logic [7:0] val);
    sb_t e;
    e.due = due;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // PHASE after edge e, given first toggle edge t0 and half-period in clocks.
  function automatic logic exp_phase(input int e, input int t0, input int half);
    if (e < t0) return 1'b1;
    return (((e - t0) / half) % 2) == 1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].due == cyc) begin
          chk_eq(sb_q[i].tag, {24'h0, out_port}, {24'h0, sb_q[i].val});
          sb_q.delete(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int p;
    int d;
    int r;
    logic ph0;

    // reset and readback
    step(3);
    reset = 1'b0;
    chk_eq("rst_out", {24'h0, out_port}, 32'h0000_00A5);
    rd_chk("rst_data",   3'd0, 32'h0000_00A5);
    rd_chk("rst_mode",   3'd1, 32'h0);
    rd_chk("rst_period", 3'd2, 32'h0);
    rd_chk("rst_ctrl",   3'd6, 32'h2);
    rd_chk("rst_rsvd",   3'd7, 32'h0);

    // static writes and atomic aliases, back to back
    sb_push(cyc + 2, "st_data",   8'h0F);
    sb_push(cyc + 3, "st_set",    8'h3F);
    sb_push(cyc + 4, "st_clear",  8'h3C);
    sb_push(cyc + 5, "st_toggle", 8'hC3);
    wr(3'd0, 32'h0F);
    wr(3'd3, 32'h30);
    wr(3'd4, 32'h03);
    wr(3'd5, 32'hFF);
    rd_chk("rd_set",   3'd3, 32'h0);
    rd_chk("rd_clear", 3'd4, 32'h0);
    rd_chk("rd_tgl",   3'd5, 32'h0);
    rd_chk("rd_data",  3'd0, 32'hC3);
    step(3);

    // blink with PERIOD=3: half-period of 4 clocks
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h01);
    wr(3'd2, 32'h3);
    w = cyc;
    for (int t = w + 2; t <= w + 25; t++)
      sb_push(t, "blink_p3", {7'h7F, exp_phase(t - 1, w + 5, 4)});
    wr(3'd6, 32'h1);
    for (int i = 0; i < 23; i++) begin
      step(1);
      rd_chk("phase_rb", 3'd6, {30'h0, exp_phase(cyc, w + 5, 4), 1'b1});
    end

    // PERIOD=0 while running: toggle every clock
    p = cyc;
    ph0 = exp_phase(p, w + 5, 4);
    for (int t = p + 2; t <= p + 12; t++)
      sb_push(t, "blink_p0", {7'h7F, ph0 ^ 1'((t - 1 - (p + 1)) & 1)});
    wr(3'd2, 32'h0);
    step(11);

    // disable: blink channel shows DATA steadily
    d = cyc;
    for (int t = d + 2; t <= d + 10; t++)
      sb_push(t, "disable", 8'hFF);
    wr(3'd6, 32'h0);
    step(9);
    rd_chk("dis_ctrl", 3'd6, 32'h2);

    // full-width writedata to an 8-bit register
    sb_push(cyc + 2, "wide_zero", 8'h00);
    sb_push(cyc + 3, "wide_ones", 8'hFF);
    wr(3'd0, 32'h0);
    wr(3'd0, 32'hFFFF_FFFF);
    rd_chk("wide_rb", 3'd0, 32'h0000_00FF);
    step(3);

    // PERIOD write in the cycle cnt==0; idle cycles confirm cnt held while disabled
    wr(3'd2, 32'h3);
    step(5);
    w = cyc;
    for (int t = w + 2; t <= w + 24; t++)
      sb_push(t, "per_coll", {7'h7F, exp_phase(t - 1, w + 11, 6)});
    wr(3'd6, 32'h1);
    step(3);
    wr(3'd2, 32'h5);
    step(20);
    rd_chk("coll_period", 3'd2, 32'h5);

    // reset mid-blink
    wr(3'd2, 32'd100);
    wr(3'd6, 32'h1);
    step(10);
    r = cyc;
    for (int t = r + 1; t <= r + 30; t++)
      sb_push(t, "rst_mid", 8'hA5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(29);
    rd_chk("rst2_ctrl",   3'd6, 32'h2);
    rd_chk("rst2_data",   3'd0, 32'hA5);
    rd_chk("rst2_mode",   3'd1, 32'h0);
    rd_chk("rst2_period", 3'd2, 32'h0);

    step(2);
    chk_eq("sb_drain", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_led_blink.md
# pio_led_blink

Parametrised Avalon-MM output port for driving LED banks from the Nios II system. It holds a WIDTH-bit data register with atomic set/clear/toggle aliases. Each channel can optionally blink from a shared programmable prescaler. It sits on the system interconnect as an Avalon-MM slave (zero wait states, zero read latency) and drives board LEDs through `out_port`.

## Interface
- WIDTH, 8: number of output channels, 1..32.
- PRESCALE_W, 24: width of PERIOD register and prescaler counter, 1..32.
- RESET_VALUE, 0: reset value of DATA and `out_port` (WIDTH bits).
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; write happens when `chipselect && !write_n`.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  combinational read data, zero-extended.
- out_port  out  WIDTH  registered LED drive.

## Operation
- Register map:
  - 0 DATA: r/w, WIDTH bits.
  - 1 MODE: r/w, WIDTH bits; 1 = blink, 0 = static.
  - 2 PERIOD: r/w, PRESCALE_W bits.
  - 3 SET: write-only; DATA |= wd. Reads 0.
  - 4 CLEAR: write-only; DATA &= ~wd. Reads 0.
  - 5 TOGGLE: write-only; DATA ^= wd. Reads 0.
  - 6 CTRL: bit0 EN is r/w; bit1 PHASE is read-only.
  - 7: reserved; reads 0, writes ignored.
- Reset values:
  - DATA = RESET_VALUE; MODE = 0; PERIOD = 0; EN = 0.
  - Counter `cnt` = 0; PHASE = 1.
  - `out_port` = RESET_VALUE.
  - Reset has priority over any simultaneous write.
- Prescaler:
  - When EN=1: if `cnt`==0, then `cnt` <= PERIOD and PHASE <= ~PHASE; otherwise `cnt` <= `cnt`-1.
  - The resulting half-period is PERIOD+1 clocks. PERIOD=0 toggles PHASE every clock.
  - When EN=0, `cnt` holds its value and PHASE is forced to 1, so blink channels show DATA steadily.
- Writing PERIOD loads `cnt` with the new value in the same edge. PHASE is unchanged. This overrides the decrement/reload for that cycle.
- Writing CTRL with EN 0->1 starts counting from the current `cnt`. Writing EN=0 sets PHASE=1 on that edge.
- Output, every clock: `out_port[i]` <= DATA[i] & (MODE[i] ? PHASE : 1).
  - Values used are the register values before the edge, so a register write reaches `out_port` on the following edge.
- Only one register write is possible per cycle. SET/CLEAR/TOGGLE are therefore atomic with respect to DATA.
- Reads have no side effects. `readdata` is a pure function of `address` and register state, independent of `chipselect`.

## Timing
- Write: sampled on the rising `clk` edge with `chipselect && !write_n`. The register updates at edge N.
- `out_port` reflects the write at edge N+1, giving 1-cycle write-to-pin latency.
- Read: combinational, 0 wait states, 0-cycle read latency. The Avalon readLatency of the slave is 0.
- PHASE toggles at edges where EN=1 and `cnt`==0 and there is no PERIOD write.
- A blink channel's `out_port` follows the PHASE toggle one edge later.
- Reset asserted mid-blink: on the next edge all state returns to its reset values. `out_port` equals RESET_VALUE after that edge.
- Boundaries:
  - PERIOD = 2^PRESCALE_W-1 gives the maximum half-period; no overflow (down-counter only).
  - WIDTH=32 uses all `writedata` bits.
  - WIDTH<32: unused `readdata` bits read 0.

## Test plan
- Reset/readback (WIDTH=8, RESET_VALUE=8'hA5): hold reset 3 cycles.
  - Required: `out_port`=A5; DATA read = 0x000000A5; MODE, PERIOD and CTRL read 0, except CTRL bit1 = 1.
- Static write and aliases:
  - Write DATA=0x0F, then `out_port`=0x0F one edge later.
  - Then SET 0x30 → 0x3F, CLEAR 0x03 → 0x3C, TOGGLE 0xFF → 0xC3.
  - Each value appears 1 cycle after its write. Reads of addresses 3/4/5 return 0.
- Blink:
  - Set DATA=0xFF, MODE=0x01, PERIOD=3, EN=1.
  - Required: `out_port[0]` alternates every 4 clocks. Bits 7:1 stay at 1.
  - PHASE readback matches `out_port[0]` one cycle earlier.
- PERIOD=0 and disable:
  - With blink running and PERIOD=0, `out_port[0]` toggles every clock.
  - Writing EN=0 gives `out_port[0]`=1 constant from 1 cycle later, and `cnt` is frozen.
- Simultaneous/boundary:
  - Write PERIOD=5 in the exact cycle `cnt`==0. Required: no PHASE toggle that cycle; the next toggle comes 6 clocks later.
  - Write `writedata`=0xFFFFFFFF to DATA with WIDTH=8. Required: readback = 0x000000FF.
- Reset mid-operation:
  - Assert reset for 1 cycle during blink with PERIOD=100. Required: `out_port`=RESET_VALUE on the next edge, EN=0, and no further toggles.
